// File: rtl/mem_access_ctrl_pkg.sv
// Shared op codes, FSM states and access-size decode for the MEM-stage access controller.
package mem_access_ctrl_pkg;

   localparam int unsigned WORD_DATA_W = 32;
   localparam int unsigned WORD_ADDR_W = 30;

   typedef enum logic [3:0] {
      MEM_OP_NOP = 4'd0,
      MEM_OP_LB  = 4'd1,
      MEM_OP_LH  = 4'd2,
      MEM_OP_LW  = 4'd3,
      MEM_OP_LBU = 4'd4,
      MEM_OP_LHU = 4'd5,
      MEM_OP_SB  = 4'd6,
      MEM_OP_SH  = 4'd7,
      MEM_OP_SW  = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_NONE = 2'd3
   } acc_size_e;

   function automatic acc_size_e op_size(input logic [3:0] op);
      case (op)
         MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: op_size = SZ_BYTE;
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: op_size = SZ_HALF;
         MEM_OP_LW, MEM_OP_SW:             op_size = SZ_WORD;
         default:                          op_size = SZ_NONE;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      op_is_store = (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-bus signals of the MEM-stage controller.
interface mem_access_ctrl_if;
   import mem_access_ctrl_pkg::*;

   logic                   flush;
   logic                   ex_en;
   logic [3:0]             ex_mem_op;
   logic [WORD_DATA_W-1:0] ex_out;
   logic [WORD_DATA_W-1:0] ex_mem_wr_data;
   logic [WORD_DATA_W-1:0] out;
   logic                   miss_align;
   logic                   mem_busy;
   logic                   bus_req;
   logic                   bus_we;
   logic [WORD_ADDR_W-1:0] bus_addr;
   logic [3:0]             bus_be;
   logic [WORD_DATA_W-1:0] bus_wr_data;
   logic [WORD_DATA_W-1:0] bus_rd_data;
   logic                   bus_ack;

   modport master (
      input  flush, ex_en, ex_mem_op, ex_out, ex_mem_wr_data, bus_rd_data, bus_ack,
      output out, miss_align, mem_busy, bus_req, bus_we, bus_addr, bus_be, bus_wr_data
   );

   modport slave (
      output flush, ex_en, ex_mem_op, ex_out, ex_mem_wr_data, bus_rd_data, bus_ack,
      input  out, miss_align, mem_busy, bus_req, bus_we, bus_addr, bus_be, bus_wr_data
   );

endinterface

// File: rtl/mem_access_ctrl_align.sv
// mem_align: lane steering, byte enables, misalignment check and load extension (pure combinational).
module mem_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_ld_op,
   input  logic [1:0]  i_ld_lane,
   input  logic [31:0] i_rd_data,
   output logic        o_is_mem,
   output logic        o_misaligned,
   output logic        o_we,
   output logic [3:0]  o_be,
   output logic [31:0] o_wr_data,
   output logic [31:0] o_rd_fmt
);

   acc_size_e   w_size;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_size       = op_size(i_op);
      o_is_mem     = (w_size != SZ_NONE);
      o_we         = op_is_store(i_op);
      o_misaligned = 1'b0;
      o_be         = '0;
      o_wr_data    = i_wr_data;
      case (w_size)
         SZ_BYTE: begin
            o_be      = 4'b0001 << i_addr_lo;
            o_wr_data = {4{i_wr_data[7:0]}};
         end
         SZ_HALF: begin
            o_misaligned = i_addr_lo[0];
            o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wr_data    = {2{i_wr_data[15:0]}};
         end
         SZ_WORD: begin
            o_misaligned = |i_addr_lo;
            o_be         = '1;
         end
         default: ;
      endcase
   end

   // Read formatting uses the lane/op captured at request time, not the live EX/MEM inputs.
   always_comb begin
      case (i_ld_lane)
         2'd0:    w_byte = i_rd_data[7:0];
         2'd1:    w_byte = i_rd_data[15:8];
         2'd2:    w_byte = i_rd_data[23:16];
         default: w_byte = i_rd_data[31:24];
      endcase
      w_half = i_ld_lane[1] ? i_rd_data[31:16] : i_rd_data[15:0];
      case (i_ld_op)
         MEM_OP_LB:  o_rd_fmt = {{24{w_byte[7]}}, w_byte};
         MEM_OP_LBU: o_rd_fmt = {24'd0, w_byte};
         MEM_OP_LH:  o_rd_fmt = {{16{w_half[15]}}, w_half};
         MEM_OP_LHU: o_rd_fmt = {16'd0, w_half};
         MEM_OP_LW:  o_rd_fmt = i_rd_data;
         default:    o_rd_fmt = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check plus a stalling req/ack bus transaction.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
(
   input logic             clk,
   input logic             reset,
   mem_access_ctrl_if.master mif
);

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic                   r_bus_req;
   logic                   r_bus_we;
   logic [WORD_ADDR_W-1:0] r_bus_addr;
   logic [3:0]             r_bus_be;
   logic [WORD_DATA_W-1:0] r_bus_wr_data;
   logic [WORD_DATA_W-1:0] r_rdata;
   logic                   r_kill;
   logic [3:0]             r_ld_op;
   logic [1:0]             r_ld_lane;

   logic                   w_is_mem;
   logic                   w_misaligned;
   logic                   w_we;
   logic [3:0]             w_be;
   logic [WORD_DATA_W-1:0] w_wr_data;
   logic [WORD_DATA_W-1:0] w_rd_fmt;
   logic                   w_mem_op;
   logic                   w_start;
   logic                   w_busy;
   logic [WORD_DATA_W-1:0] w_out;

   mem_align u_align (
      .i_op         (mif.ex_mem_op),
      .i_addr_lo    (mif.ex_out[1:0]),
      .i_wr_data    (mif.ex_mem_wr_data),
      .i_ld_op      (r_ld_op),
      .i_ld_lane    (r_ld_lane),
      .i_rd_data    (mif.bus_rd_data),
      .o_is_mem     (w_is_mem),
      .o_misaligned (w_misaligned),
      .o_we         (w_we),
      .o_be         (w_be),
      .o_wr_data    (w_wr_data),
      .o_rd_fmt     (w_rd_fmt)
   );

   assign w_mem_op = mif.ex_en & w_is_mem;
   assign w_start  = (r_state == ST_IDLE) & w_mem_op & ~w_misaligned & ~mif.flush;

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_out       = '0;
      case (r_state)
         ST_IDLE: begin
            w_out = w_mem_op ? '0 : mif.ex_out;
            if (w_start) begin
               w_busy      = 1'b1;
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_busy = 1'b1;
            // A flush arriving with the ack kills the result just like an earlier one.
            if (mif.bus_ack)
               w_state_nxt = (r_kill | mif.flush) ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            w_out       = r_rdata;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_addr    <= '0;
         r_bus_be      <= '0;
         r_bus_wr_data <= '0;
         r_rdata       <= '0;
         r_kill        <= 1'b0;
         r_ld_op       <= MEM_OP_NOP;
         r_ld_lane     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_bus_req     <= 1'b1;
            r_bus_we      <= w_we;
            r_bus_addr    <= mif.ex_out[31:2];
            r_bus_be      <= w_be;
            r_bus_wr_data <= w_wr_data;
            r_ld_op       <= w_we ? MEM_OP_NOP : mif.ex_mem_op;
            r_ld_lane     <= mif.ex_out[1:0];
            r_kill        <= 1'b0;
         end
         if (r_state == ST_ACCESS) begin
            if (mif.flush)
               r_kill <= 1'b1;
            if (mif.bus_ack) begin
               r_bus_req <= 1'b0;
               r_rdata   <= w_rd_fmt;
               r_kill    <= 1'b0;
            end
         end
      end
   end

   assign mif.out         = w_out;
   assign mif.miss_align  = w_mem_op & w_misaligned;
   assign mif.mem_busy    = w_busy;
   assign mif.bus_req     = r_bus_req;
   assign mif.bus_we      = r_bus_we;
   assign mif.bus_addr    = r_bus_addr;
   assign mif.bus_be      = r_bus_be;
   assign mif.bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl: the driver expands each instruction into a per-cycle expected trace.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_ctrl_if mif ();

   mem_access_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .mif   (mif)
   );

   typedef struct {
      int          id;
      logic        chk_out;
      logic [31:0] out;
      logic        miss;
      logic        busy;
      logic        req;
      logic        chk_bus;
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic        chk_wd;
      logic [31:0] wd;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Compare process: one expected record per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.chk_out) chk("out", e.id, mif.out, e.out);
         chk("miss_align", e.id, 32'(mif.miss_align), 32'(e.miss));
         chk("mem_busy",   e.id, 32'(mif.mem_busy),   32'(e.busy));
         chk("bus_req",    e.id, 32'(mif.bus_req),    32'(e.req));
         if (e.chk_bus) begin
            chk("bus_we",   e.id, 32'(mif.bus_we),   32'(e.we));
            chk("bus_addr", e.id, 32'(mif.bus_addr), 32'(e.addr));
            chk("bus_be",   e.id, 32'(mif.bus_be),   32'(e.be));
         end
         if (e.chk_wd) chk("bus_wr_data", e.id, mif.bus_wr_data, e.wd);
      end
   end

   function automatic exp_t blank(input int id);
      exp_t e;
      e.id = id; e.chk_out = 1'b0; e.out = '0; e.miss = 1'b0; e.busy = 1'b0; e.req = 1'b0;
      e.chk_bus = 1'b0; e.we = 1'b0; e.addr = '0; e.be = '0; e.chk_wd = 1'b0; e.wd = '0;
      return e;
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
   endfunction

   function automatic logic [31:0] steer(input logic [3:0] op, input logic [31:0] d);
      if (op == MEM_OP_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (op == MEM_OP_SH) return {d[15:0], d[15:0]};
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mif.flush = 1'b0; mif.ex_en = 1'b0; mif.ex_mem_op = MEM_OP_NOP; mif.ex_out = '0;
      mif.ex_mem_wr_data = '0; mif.bus_rd_data = '0; mif.bus_ack = 1'b0;
   endtask

   // Aligned memory instruction: one IDLE cycle, waits+1 ACCESS cycles, then DONE unless killed.
   task automatic run_mem(input int id, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                          input int flush_at, input logic [3:0] lit_be, input logic [31:0] lit_out);
      exp_t e;
      logic st;
      bit   killed;
      st     = is_store(op);
      killed = (flush_at >= 0) && (flush_at <= waits);
      mif.ex_en = 1'b1; mif.ex_mem_op = op; mif.ex_out = addr; mif.ex_mem_wr_data = wdata;
      mif.bus_rd_data = rdata; mif.flush = 1'b0; mif.bus_ack = 1'b0;
      e = blank(id); e.busy = 1'b1;
      q.push_back(e);
      step();
      for (int i = 0; i <= waits; i++) begin
         mif.bus_ack = (i == waits);
         mif.flush   = (i == flush_at);
         e = blank(id); e.busy = 1'b1; e.req = 1'b1; e.chk_bus = 1'b1;
         e.we = st; e.addr = addr[31:2]; e.be = lit_be; e.chk_wd = st; e.wd = steer(op, wdata);
         q.push_back(e);
         step();
      end
      mif.bus_ack = 1'b0;
      mif.flush   = 1'b0;
      if (!killed) begin
         e = blank(id); e.chk_out = 1'b1; e.out = lit_out;
         q.push_back(e);
         step();
      end
   endtask

   task automatic run_one(input int id, input logic en, input logic [3:0] op, input logic [31:0] exo,
                          input logic fl, input logic chk_out, input logic [31:0] exp_out, input logic miss);
      exp_t e;
      mif.ex_en = en; mif.ex_mem_op = op; mif.ex_out = exo; mif.flush = fl; mif.bus_ack = 1'b0;
      e = blank(id); e.chk_out = chk_out; e.out = exp_out; e.miss = miss;
      q.push_back(e);
      step();
      mif.flush = 1'b0;
   endtask

   initial begin
      exp_t e;
      idle_inputs();
      reset = 1'b1;
      step();
      e = blank(0); e.chk_out = 1'b1; e.chk_bus = 1'b1; e.chk_wd = 1'b1;
      q.push_back(e);
      step();
      reset = 1'b0;

      run_mem(1, MEM_OP_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, -1, 4'b1111, 32'hDEAD_BEEF);
      run_mem(2, MEM_OP_LB,  32'h0000_0103, 32'h0,         32'h80FF_FFFF, 3, -1, 4'b1000, 32'hFFFF_FF80);
      run_mem(3, MEM_OP_SH,  32'h0000_0022, 32'h0000_1234, 32'h5555_5555, 0, -1, 4'b1100, 32'h0);
      run_mem(4, MEM_OP_LBU, 32'h0000_0101, 32'h0,         32'h1234_5678, 1, -1, 4'b0010, 32'h0000_0056);
      run_mem(5, MEM_OP_LH,  32'h0000_0102, 32'h0,         32'h8001_7FFF, 0, -1, 4'b1100, 32'hFFFF_8001);
      run_mem(6, MEM_OP_LHU, 32'h0000_0100, 32'h0,         32'h1234_F00D, 2, -1, 4'b0011, 32'h0000_F00D);
      run_mem(7, MEM_OP_SB,  32'h0000_0201, 32'h0000_00AB, 32'hFFFF_FFFF, 0, -1, 4'b0010, 32'h0);
      run_mem(8, MEM_OP_SW,  32'h0000_0204, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, -1, 4'b1111, 32'h0);
      run_mem(9, MEM_OP_LB,  32'h0000_0100, 32'h0,         32'hFFFF_FF7F, 0, -1, 4'b0001, 32'h0000_007F);

      run_one(10, 1'b1, MEM_OP_LW,  32'h0000_0101, 1'b0, 1'b1, 32'h0, 1'b1);
      run_one(11, 1'b1, MEM_OP_LH,  32'h0000_0103, 1'b0, 1'b1, 32'h0, 1'b1);
      run_one(12, 1'b1, MEM_OP_SW,  32'h0000_0102, 1'b0, 1'b1, 32'h0, 1'b1);
      run_one(13, 1'b1, MEM_OP_NOP, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
      run_one(14, 1'b0, MEM_OP_LW,  32'h0000_ABCD, 1'b0, 1'b1, 32'h0000_ABCD, 1'b0);
      run_one(15, 1'b1, MEM_OP_LW,  32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b0);

      run_mem(16, MEM_OP_LW, 32'h0000_0300, 32'h0, 32'h1111_1111, 2, 0, 4'b1111, 32'h0);
      run_mem(17, MEM_OP_LH, 32'h0000_0040, 32'h0, 32'h2222_2222, 1, 1, 4'b0011, 32'h0);
      run_mem(18, MEM_OP_LW, 32'h0000_0104, 32'h0, 32'h0BAD_CAFE, 0, -1, 4'b1111, 32'h0BAD_CAFE);

      // Reset in ACCESS: request falls at the next edge and a late ack is ignored.
      mif.ex_en = 1'b1; mif.ex_mem_op = MEM_OP_LW; mif.ex_out = 32'h0000_0500; mif.bus_rd_data = 32'h9999_9999;
      e = blank(19); e.busy = 1'b1; q.push_back(e); step();
      e = blank(19); e.busy = 1'b1; e.req = 1'b1; q.push_back(e); step();
      reset = 1'b1;
      e = blank(19); e.busy = 1'b1; e.req = 1'b1; q.push_back(e); step();
      reset = 1'b0; mif.ex_en = 1'b0; mif.ex_out = 32'h0000_0777; mif.bus_ack = 1'b1;
      e = blank(19); e.chk_out = 1'b1; e.out = 32'h0000_0777; q.push_back(e); step();
      mif.bus_ack = 1'b0;
      e = blank(19); e.chk_out = 1'b1; e.out = 32'h0000_0777; q.push_back(e); step();

      run_mem(20, MEM_OP_LHU, 32'h0000_0602, 32'h0, 32'hBEEF_0000, 0, -1, 4'b1100, 32'h0000_BEEF);

      idle_inputs();
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
